// File: rtl/level_sequencer.sv
// Game level sequencer: tracks level, score and lives through a five-state game FSM.
// Define LEVEL_SEQ_HEX_EN to add the hex_level 7-segment output and its decoder.
module level_sequencer #(
  parameter int unsigned HITS_PER_LEVEL = 5,
  parameter int unsigned LIVES          = 3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  input  logic       tick,
  output logic [2:0] level,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       playing,
  output logic       level_up,
  output logic       game_over,
`ifdef LEVEL_SEQ_HEX_EN
  output logic       win,
  output logic [6:0] hex_level
`else
  output logic       win
`endif
);

  localparam logic [1:0] LivesInit  = 2'(LIVES);
  localparam logic [3:0] HitsTarget = 4'(HITS_PER_LEVEL);
  localparam logic [2:0] MaxLevel   = 3'd5;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StPlay     = 3'd1,
    StLevelUp  = 3'd2,
    StGameOver = 3'd3,
    StWin      = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] level_q, level_d;
  logic [7:0] score_q, score_d;
  logic [1:0] lives_q, lives_d;
  logic [3:0] hit_cnt_q, hit_cnt_d;
  logic       level_up_q, level_up_d;
  logic       playing_q, game_over_q, win_q;

  always_comb begin
    state_d    = state_q;
    level_d    = level_q;
    score_d    = score_q;
    lives_d    = lives_q;
    hit_cnt_d  = hit_cnt_q;
    level_up_d = 1'b0;
    case (state_q)
      StIdle, StGameOver, StWin: begin
        if (start) begin
          state_d   = StPlay;
          level_d   = 3'd1;
          score_d   = 8'd0;
          lives_d   = LivesInit;
          hit_cnt_d = 4'd0;
        end
      end
      StPlay: begin
        // A miss wins over a simultaneous hit; the hit is dropped entirely.
        if (miss) begin
          if (lives_q <= 2'd1) begin
            lives_d = 2'd0;
            state_d = StGameOver;
          end else begin
            lives_d = lives_q - 2'd1;
          end
        end else if (hit) begin
          if (score_q != 8'hff) score_d = score_q + 8'd1;
          hit_cnt_d = hit_cnt_q + 4'd1;
          if (hit_cnt_q + 4'd1 == HitsTarget) begin
            state_d = (level_q == MaxLevel) ? StWin : StLevelUp;
          end
        end
      end
      StLevelUp: begin
        if (tick) begin
          if (level_q < MaxLevel) level_d = level_q + 3'd1;
          hit_cnt_d  = 4'd0;
          level_up_d = 1'b1;
          state_d    = StPlay;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      level_q     <= 3'd1;
      score_q     <= 8'd0;
      lives_q     <= LivesInit;
      hit_cnt_q   <= 4'd0;
      level_up_q  <= 1'b0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      hit_cnt_q   <= hit_cnt_d;
      level_up_q  <= level_up_d;
      playing_q   <= (state_d == StPlay) || (state_d == StLevelUp);
      game_over_q <= (state_d == StGameOver);
      win_q       <= (state_d == StWin);
    end
  end

  assign level     = level_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign level_up  = level_up_q;
  assign playing   = playing_q;
  assign game_over = game_over_q;
  assign win       = win_q;

`ifdef LEVEL_SEQ_HEX_EN
  // Segment order is {a,b,c,d,e,f,g}, active low.
  always_comb begin
    hex_level = 7'b1111111;
    case (level_q)
      3'd1:    hex_level = 7'b1001111;
      3'd2:    hex_level = 7'b0010010;
      3'd3:    hex_level = 7'b0000110;
      3'd4:    hex_level = 7'b1001100;
      3'd5:    hex_level = 7'b0100100;
      default: hex_level = 7'b1111111;
    endcase
  end
`endif

endmodule

// File: tb/tb_level_sequencer.sv
// Self-checking bench for level_sequencer: directed game scenarios plus random play,
// all checked against an event-level game model.
module tb_level_sequencer;

  localparam int Hits  = 5;
  localparam int Lives = 3;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       start = 1'b0, hit = 1'b0, miss = 1'b0, tick = 1'b0;
  logic [2:0] level;
  logic [7:0] score;
  logic [1:0] lives;
  logic       playing, level_up, game_over, win;
`ifdef LEVEL_SEQ_HEX_EN
  logic [6:0] hex_level;
`endif

  level_sequencer #(.HITS_PER_LEVEL(Hits), .LIVES(Lives)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .start     (start),
    .hit       (hit),
    .miss      (miss),
    .tick      (tick),
    .level     (level),
    .score     (score),
    .lives     (lives),
    .playing   (playing),
    .level_up  (level_up),
    .game_over (game_over),
`ifdef LEVEL_SEQ_HEX_EN
    .win       (win),
    .hex_level (hex_level)
`else
    .win       (win)
`endif
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  // Game model: phase 0=idle, 1=play, 2=waiting for level tick, 3=lost, 4=won.
  int m_phase, m_level, m_score, m_lives, m_hits, m_lu;
  int seg_tbl [8] = '{127, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
                      127, 127};

  task automatic check_value(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_value("level", int'(level), m_level);
    check_value("score", int'(score), m_score);
    check_value("lives", int'(lives), m_lives);
    check_value("playing", int'(playing), int'(m_phase == 1 || m_phase == 2));
    check_value("level_up", int'(level_up), m_lu);
    check_value("game_over", int'(game_over), int'(m_phase == 3));
    check_value("win", int'(win), int'(m_phase == 4));
`ifdef LEVEL_SEQ_HEX_EN
    check_value("hex_level", int'(hex_level), seg_tbl[m_level]);
`endif
  endtask

  task automatic model_reset();
    m_phase = 0; m_level = 1; m_score = 0; m_lives = Lives; m_hits = 0; m_lu = 0;
  endtask

  task automatic model_step(input bit s, input bit h, input bit m, input bit t);
    m_lu = 0;
    if (m_phase == 0 || m_phase == 3 || m_phase == 4) begin
      if (s) begin
        m_phase = 1; m_level = 1; m_score = 0; m_lives = Lives; m_hits = 0;
      end
    end else if (m_phase == 1) begin
      if (m) begin
        m_lives = m_lives - 1;
        if (m_lives == 0) m_phase = 3;
      end else if (h) begin
        if (m_score < 255) m_score++;
        m_hits++;
        if (m_hits == Hits) m_phase = (m_level == 5) ? 4 : 2;
      end
    end else if (t) begin
      m_level++; m_hits = 0; m_lu = 1; m_phase = 1;
    end
  endtask

  // One clock: drive inputs, advance the model, check just after the edge.
  task automatic step(input bit s, input bit h, input bit m, input bit t);
    start = s; hit = h; miss = m; tick = t;
    model_step(s, h, m, t);
    @(posedge Clock);
    #1;
    check_all();
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before any edge.
  task automatic pulse_reset();
    start = 0; hit = 0; miss = 0; tick = 0;
    #2 Reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #1 Reset = 1'b0;
  endtask

  initial begin
    @(posedge Clock);
    #1;
    pulse_reset();

    // No start after reset: nothing moves.
    step(0, 1, 1, 1);
    step(0, 1, 0, 0);

    // Start, five hits, stray hits during level-up, then the tick.
    step(1, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    check_value("score_hold_levelup", int'(score), 5);
    step(0, 0, 0, 1);
    check_value("level_after_tick", int'(level), 2);
    check_value("level_up_pulse", int'(level_up), 1);
    step(0, 0, 0, 1);
    check_value("level_up_one_cycle", int'(level_up), 0);

    // Hit+miss together at lives 2, then lose all lives and restart.
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    check_value("lives_hit_miss", int'(lives), 1);
    check_value("score_hit_miss", int'(score), 5);
    step(0, 0, 1, 0);
    check_value("game_over_set", int'(game_over), 1);
    step(0, 1, 0, 1);
    step(1, 0, 0, 0);
    check_value("restart_lives", int'(lives), Lives);

    // Full 25-hit game to WIN, then extra hits have no effect.
    for (int lv = 0; lv < 5; lv++) begin
      repeat (Hits) step(0, 1, 0, 0);
      if (lv < 4) step(0, 0, 0, 1);
    end
    check_value("win_level", int'(level), 5);
    check_value("win_flag", int'(win), 1);
    repeat (3) step(0, 1, 0, 1);
    check_value("win_score", int'(score), 25);

    // Reset in the middle of the level-3 level-up wait.
    step(1, 0, 0, 0);
    for (int lv = 0; lv < 3; lv++) begin
      repeat (Hits) step(0, 1, 0, 0);
      if (lv < 2) step(0, 0, 0, 1);
    end
    check_value("pre_reset_level", int'(level), 3);
    pulse_reset();

    // Random play with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) pulse_reset();
      else step($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/level_sequencer.md
LEVEL_SEQUENCER -- requirements
Module: level_sequencer

Interface
REQ-001 The block SHALL have parameter HITS_PER_LEVEL, default 5, meaning the hits needed to leave a level (legal 2..15).
REQ-002 The block SHALL have parameter LIVES, default 3, meaning the lives granted at game start (legal 1..3).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Port: Clock  input  1  the single clock; all state changes on its rising edge.
REQ-005 Port: Reset  input  1  asynchronous, active-high reset.
REQ-006 Port: start  input  1  level-sampled start/restart request.
REQ-007 Port: hit  input  1  one-cycle score event.
REQ-008 Port: miss  input  1  one-cycle life-loss event.
REQ-009 Port: tick  input  1  one-cycle period pulse from the pixel rate divider.
REQ-010 Port: level  output  3  current level, encoded 1..5, feeding the rate divider level input.
REQ-011 Port: score  output  8  total hits this game.
REQ-012 Port: lives  output  2  remaining lives.
REQ-013 Port: playing  output  1  high in PLAY and LEVEL_UP.
REQ-014 Port: level_up  output  1  one-cycle pulse on each level increment.
REQ-015 Port: game_over  output  1  high in GAME_OVER.
REQ-016 Port: win  output  1  high in WIN.
REQ-017 Port: hex_level  output  7  active-low 7-segment digit for level, order a..g; present only when LEVEL_SEQ_HEX_EN is defined.

Function
REQ-018 The FSM SHALL have states IDLE, PLAY, LEVEL_UP, GAME_OVER and WIN, registered and encoded in 3 bits.
REQ-019 In IDLE, start=1 SHALL load level=1, score=0, lives=LIVES, hit_cnt=0 and enter PLAY on the next edge.
REQ-020 In PLAY, hit with miss=0 SHALL increment score, saturating at 255, and increment the internal hit_cnt.
REQ-021 In PLAY, a hit that makes hit_cnt equal HITS_PER_LEVEL SHALL enter WIN if level=5, else LEVEL_UP.
REQ-022 In PLAY, miss SHALL decrement lives; a miss with lives=1 SHALL set lives=0 and enter GAME_OVER.
REQ-023 On simultaneous hit and miss in PLAY, the miss SHALL take priority and the hit SHALL be discarded.
REQ-024 LEVEL_UP SHALL wait for tick=1; on that edge level increments, hit_cnt clears, level_up pulses one cycle, and state returns to PLAY.
REQ-025 LEVEL_UP SHALL ignore hit and miss, so level changes align to a divider period boundary.
REQ-026 GAME_OVER and WIN SHALL hold all outputs; start=1 SHALL reinitialise as in REQ-019 and enter PLAY on the next edge.
REQ-027 start SHALL be ignored in PLAY and LEVEL_UP.
REQ-028 level SHALL never leave 1..5, and tick SHALL have no effect outside LEVEL_UP.
REQ-029 level, score, lives, playing, game_over and win SHALL be registered, with zero-cycle latency from state.

Reset
REQ-030 Reset=1 SHALL immediately force IDLE, level=1, score=0, lives=LIVES, hit_cnt=0, level_up=0, playing=0, game_over=0 and win=0, in any state, including mid-LEVEL_UP.
REQ-031 After Reset deasserts, the first state change SHALL require start=1.

Configuration
REQ-032 With LEVEL_SEQ_HEX_EN defined, hex_level SHALL decode level combinationally: 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, other=1111111.
REQ-033 Without LEVEL_SEQ_HEX_EN, the hex_level port and decoder SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-034 Reset, start, then 5 hits -> LEVEL_UP; the next tick gives level=2, a level_up pulse of exactly 1 cycle, and score=5.
REQ-035 Hits issued while in LEVEL_UP before tick -> score unchanged, and level increments only on the tick edge.
REQ-036 3 misses in PLAY (LIVES=3) -> lives 2,1,0, then game_over=1 and playing=0; start then gives PLAY with lives=3, score=0, level=1.
REQ-037 hit and miss in the same cycle at lives=2 -> lives=1, score unchanged, hit_cnt unchanged.
REQ-038 25 hits plus 4 ticks -> level=5 after the 20th hit's tick, then the 25th hit gives win=1; further hits leave score at 25.
REQ-039 Reset asserted asynchronously mid-LEVEL_UP at level=3 -> outputs at reset values before the next edge, and hex_level=1001111 when LEVEL_SEQ_HEX_EN is defined.
